// File: rtl/serial_paralelo_pkg.sv
// Shared types and defaults for the serial-to-parallel aligning receiver.
// The state encoding is kept here so the top and the lock FSM agree on it.
package serial_paralelo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int          DEF_DATA_W     = 8;
  localparam logic [7:0]  DEF_COMMA      = 8'hBC;
  localparam int          DEF_LOCK_COUNT = 4;
  localparam int          DEF_MAX_GAP    = 16;

  // Counter width able to hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/serial_paralelo_lock_fsm.sv
// Lock qualification FSM: counts aligned commas to acquire lock and
// non-comma words to drop it. Owns comma_cnt and gap_cnt.
module serial_paralelo_lock_fsm
  import serial_paralelo_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MAX_GAP    = DEF_MAX_GAP
) (
  input  logic   clk_32f,
  input  logic   reset,
  input  logic   i_is_comma,
  input  logic   i_boundary,
  output state_t o_state,
  output logic   o_bit_clr,
  output logic   o_active,
  output logic   o_lock_lost
);

  localparam int             CCW      = cnt_w(LOCK_COUNT);
  localparam int             GW       = cnt_w(MAX_GAP);
  localparam logic [CCW-1:0] LOCK_TGT = CCW'(LOCK_COUNT);
  localparam logic [GW-1:0]  GAP_TGT  = GW'(MAX_GAP);
  localparam logic           GAP_EN   = (MAX_GAP != 0);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CCW-1:0]  r_comma_cnt;
  logic [CCW-1:0]  w_comma_nxt;
  logic [CCW-1:0]  w_comma_inc;
  logic [GW-1:0]   r_gap_cnt;
  logic [GW-1:0]   w_gap_nxt;
  logic [GW-1:0]   w_gap_inc;
  logic            r_active;
  logic            r_lock_lost;
  logic            w_lost_nxt;
  logic            w_bit_clr;

  assign w_comma_inc = r_comma_cnt + CCW'(1);
  assign w_gap_inc   = r_gap_cnt + GW'(1);

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_comma_nxt = r_comma_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_lost_nxt  = 1'b0;
    w_bit_clr   = 1'b0;
    case (r_state)
      SEARCH: begin
        // Bit-granular acquisition: any window match re-anchors the boundary.
        if (i_is_comma) begin
          w_bit_clr   = 1'b1;
          w_comma_nxt = CCW'(1);
          w_gap_nxt   = '0;
          w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
        end else begin
          w_state_nxt = SEARCH;
        end
      end
      ALIGN: begin
        if (i_boundary) begin
          if (i_is_comma) begin
            w_comma_nxt = w_comma_inc;
            if (w_comma_inc == LOCK_TGT) begin
              w_state_nxt = LOCKED;
              w_gap_nxt   = '0;
            end else begin
              w_state_nxt = ALIGN;
            end
          end else begin
            w_state_nxt = SEARCH;
            w_comma_nxt = '0;
          end
        end else begin
          w_state_nxt = ALIGN;
        end
      end
      LOCKED: begin
        if (i_boundary) begin
          if (i_is_comma) begin
            w_gap_nxt = '0;
          end else if (GAP_EN && (w_gap_inc == GAP_TGT)) begin
            w_state_nxt = SEARCH;
            w_lost_nxt  = 1'b1;
            w_gap_nxt   = '0;
            w_comma_nxt = '0;
          end else if (GAP_EN) begin
            w_gap_nxt = w_gap_inc;
          end else begin
            w_gap_nxt = '0;
          end
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_comma_nxt = '0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_comma_cnt <= '0;
      r_gap_cnt   <= '0;
      r_active    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_active    <= (w_state_nxt == LOCKED);
      r_lock_lost <= w_lost_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_bit_clr   = w_bit_clr;
  assign o_active    = r_active;
  assign o_lock_lost = r_lock_lost;

endmodule

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel receiver with sliding-window comma alignment, running
// entirely from the serial bit clock. Words are delivered with zero added latency.
module serial_paralelo_align
  import serial_paralelo_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] COMMA      = DATA_W'(DEF_COMMA),
  parameter int                LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int                MAX_GAP    = DEF_MAX_GAP
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              word_strobe,
  output logic              active,
  output logic              lock_lost
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  // The oldest bit is never needed again once the window is formed.
  logic [DATA_W-2:0] r_sr;
  logic [DATA_W-1:0] w_window;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_strobe;
  logic              w_boundary;
  logic              w_is_comma;
  logic              w_bit_clr;
  logic              w_locked;
  logic              w_active;
  logic              w_lock_lost;
  state_t            w_state;

  assign w_window   = {r_sr, data_in};
  assign w_is_comma = (w_window == COMMA);
  assign w_boundary = (r_bit_cnt == BIT_LAST);
  assign w_locked   = (w_state == LOCKED);

  serial_paralelo_lock_fsm #(
    .LOCK_COUNT (LOCK_COUNT),
    .MAX_GAP    (MAX_GAP)
  ) u_lock_fsm (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_is_comma  (w_is_comma),
    .i_boundary  (w_boundary),
    .o_state     (w_state),
    .o_bit_clr   (w_bit_clr),
    .o_active    (w_active),
    .o_lock_lost (w_lock_lost)
  );

  // Serial shift register and word bit counter.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sr <= w_window[DATA_W-2:0];
      if (w_bit_clr || w_boundary) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  // Word presentation; only boundaries seen while already locked are delivered.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else if (w_locked && w_boundary) begin
      r_data   <= w_window;
      r_valid  <= !w_is_comma;
      r_strobe <= 1'b1;
    end else if (w_locked) begin
      r_data   <= r_data;
      r_valid  <= r_valid;
      r_strobe <= 1'b0;
    end else begin
      r_data   <= r_data;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign word_strobe = r_strobe;
  assign active      = w_active;
  assign lock_lost   = w_lock_lost;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed self-checking bench for serial_paralelo_align at its default
// parameters (8-bit words, comma BC, lock after 4 commas, loss after 16 gaps).
module tb_serial_paralelo_align;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       word_strobe;
  logic       active;
  logic       lock_lost;

  int n_checks;
  int n_fail;
  int n_strobe;
  int n_lost;
  int base_strobe;
  int base_lost;

  serial_paralelo_align dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .word_strobe (word_strobe),
    .active      (active),
    .lock_lost   (lock_lost)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one bit, let one edge sample it, then look 1 time unit later.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    n_strobe += int'(word_strobe);
    n_lost   += int'(lock_lost);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(data_out),    32'h0);
    check({tag, "_valid"},  32'(valid_out),   32'h0);
    check({tag, "_strobe"}, 32'(word_strobe), 32'h0);
    check({tag, "_active"}, 32'(active),      32'h0);
    check({tag, "_lost"},   32'(lock_lost),   32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_strobe = 0;
    n_lost   = 0;
    reset    = 1'b1;
    data_in  = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;

    // Offset lock: three junk bits then four commas, then A5.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 0; k < 4; k++) begin
      send_word(8'hBC);
      check($sformatf("t1_active_bc%0d", k + 1), 32'(active), (k == 3) ? 32'h1 : 32'h0);
    end
    check("t1_no_strobe_pre_lock", 32'(n_strobe), 32'h0);
    check("t1_valid_at_entry", 32'(valid_out), 32'h0);
    send_word(8'hA5);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_valid", 32'(valid_out), 32'h1);
    check("t1_strobe", 32'(word_strobe), 32'h1);
    send_bit(1'b0);
    check("t1_strobe_drop", 32'(word_strobe), 32'h0);
    check("t1_strobe_count", 32'(n_strobe), 32'h1);

    // Broken qualification, starting clean from reset.
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset    = 1'b0;
    n_strobe = 0;
    check("t2_active_rst", 32'(active), 32'h0);
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    send_word(8'h00);
    check("t2_active_after_00", 32'(active), 32'h0);
    send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
    check("t2_active_3fresh", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t2_active_4fresh", 32'(active), 32'h1);
    check("t2_no_strobes", 32'(n_strobe), 32'h0);

    // Idle comma while locked.
    base_strobe = n_strobe;
    send_word(8'h3C);
    check("t3_data_3c", 32'(data_out), 32'h3C);
    check("t3_valid_3c", 32'(valid_out), 32'h1);
    check("t3_strobe_3c", 32'(word_strobe), 32'h1);
    send_word(8'hBC);
    check("t3_data_bc", 32'(data_out), 32'hBC);
    check("t3_valid_bc", 32'(valid_out), 32'h0);
    send_word(8'h7E);
    check("t3_data_7e", 32'(data_out), 32'h7E);
    check("t3_valid_7e", 32'(valid_out), 32'h1);
    check("t3_strobe_count", 32'(n_strobe - base_strobe), 32'h3);

    // Gap loss: comma clears the gap, then 16 non-comma words.
    send_word(8'hBC);
    base_lost = n_lost;
    for (int k = 0; k < 15; k++) send_word(8'h55);
    check("t4_active_15", 32'(active), 32'h1);
    check("t4_no_lost_15", 32'(n_lost - base_lost), 32'h0);
    send_word(8'h55);
    check("t4_data_16", 32'(data_out), 32'h55);
    check("t4_valid_16", 32'(valid_out), 32'h1);
    check("t4_strobe_16", 32'(word_strobe), 32'h1);
    check("t4_active_16", 32'(active), 32'h0);
    check("t4_lost_16", 32'(lock_lost), 32'h1);
    base_strobe = n_strobe;
    send_bit(1'b0);
    check("t4_valid_after", 32'(valid_out), 32'h0);
    check("t4_lost_after", 32'(lock_lost), 32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_word(8'h55);
    check("t4_no_more_strobes", 32'(n_strobe - base_strobe), 32'h0);
    check("t4_lost_once", 32'(n_lost - base_lost), 32'h1);
    check("t4_data_held", 32'(data_out), 32'h55);

    // Gap reset: a single comma mid-run keeps lock.
    for (int k = 0; k < 4; k++) send_word(8'hBC);
    check("t5_relock", 32'(active), 32'h1);
    base_lost = n_lost;
    for (int k = 0; k < 15; k++) send_word(8'h55);
    send_word(8'hBC);
    for (int k = 0; k < 15; k++) send_word(8'h55);
    check("t5_active", 32'(active), 32'h1);
    check("t5_no_lost", 32'(n_lost - base_lost), 32'h0);
    check("t5_valid", 32'(valid_out), 32'h1);
    check("t5_data", 32'(data_out), 32'h55);

    // Asynchronous reset between edges while valid_out is high.
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6_async");
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) send_word(8'hBC);
    check("t6_active_3", 32'(active), 32'h0);
    send_word(8'hBC);
    check("t6_active_4", 32'(active), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_align.md
Name: serial_paralelo_align

Overview:
- Parametrised successor to the fixed 8-bit serial-to-parallel receiver on the physical-layer RX path.
- Runs from the serial clock only; no word-rate clock is needed.
- Finds the word boundary by sliding-window comma detection, qualifies lock after N back-to-back aligned commas, and drops lock after a programmable comma-less gap.
- Delivers words to the downstream byte-striping / unstriping logic with valid and strobe qualifiers.

Parameters:
- DATA_W, 8: word width in bits, ≥4.
- COMMA, 8'hBC: alignment/idle symbol, DATA_W bits wide.
- LOCK_COUNT, 4: consecutive word-aligned commas required to lock, ≥1.
- MAX_GAP, 16: consecutive non-comma words that force loss of lock; 0 disables loss detection.

Ports:
- clk_32f, input, 1: serial bit clock. All logic is on the rising edge.
- reset, input, 1: asynchronous reset, active-high.
- data_in, input, 1: serial data, MSB of each word first.
- data_out, output, DATA_W: last completed word.
- valid_out, output, 1: level; high while the held data_out is a non-comma word received in lock.
- word_strobe, output, 1: one-cycle pulse per word boundary while locked.
- active, output, 1: high in LOCKED.
- lock_lost, output, 1: one-cycle pulse when LOCKED exits due to gap.

Behaviour:
- Reset: asserting reset forces every output and all state to 0 immediately, with no clock edge required. State returns to SEARCH; bit_cnt, comma_cnt and gap_cnt clear to 0.
- Shift register:
  - sr <= {sr[DATA_W-2:0], data_in} on every edge.
  - window = {sr[DATA_W-2:0], data_in}, combinational; it is the word completed at this edge.
- bit_cnt:
  - Counts modulo DATA_W.
  - A boundary edge is any edge where bit_cnt == DATA_W-1.
- States: SEARCH, ALIGN, LOCKED. Encoding lives in the package.
- SEARCH:
  - On any edge where window == COMMA: bit_cnt <= 0 and comma_cnt <= 1.
  - Next state is LOCKED if LOCK_COUNT == 1, else ALIGN.
  - Boundary is bit-granular, so any bit offset is acquired.
- ALIGN, at each boundary edge:
  - If window == COMMA: comma_cnt++. When the new count equals LOCK_COUNT, go to LOCKED with gap_cnt <= 0.
  - If window != COMMA: go to SEARCH with comma_cnt <= 0.
  - No partial-credit retention.
- Lock entry:
  - active rises at the same edge that samples the last bit of the qualifying comma.
  - That comma is not strobed. data_out and valid_out are unchanged at lock entry.
- LOCKED, at each boundary edge:
  - data_out <= window, valid_out <= (window != COMMA), and word_strobe is high for the following cycle.
  - Zero added latency: data_out changes on the edge that samples the word's last bit.
- Gap handling in LOCKED:
  - gap_cnt clears on a comma word and increments on a non-comma word.
  - If MAX_GAP != 0 and the incremented gap_cnt == MAX_GAP, the word is still presented (data_out/valid_out/strobe as normal).
  - On that same edge: active <= 0, lock_lost pulses, state goes to SEARCH, and counters clear.
  - valid_out clears at the next edge.
- SEARCH/ALIGN outputs: valid_out = 0, word_strobe = 0, and data_out holds its last value.
- Comma detection in SEARCH is pattern-only. An unaligned false comma is rejected in ALIGN by the next boundary check.
- Counter widths are $clog2 of their maximum plus 1. No wrap is possible, because the counters clear before overflow.
- Reset takes priority over every simultaneous event.

Decomposition:
- Shared package (serial_paralelo_pkg):
  - State encoding localparams: SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2.
  - Default COMMA 8'hBC.
  - Default LOCK_COUNT/MAX_GAP.
- One sub-module, serial_paralelo_lock_fsm:
  - Inputs: window-is-comma, boundary.
  - Owns comma_cnt and gap_cnt.
  - Outputs: state, bit_cnt clear, lock_lost.
- Top module owns sr, bit_cnt and the output registers.

Test Plan (DATA_W=8, COMMA=BC, LOCK_COUNT=4, MAX_GAP=16):
- Offset lock: 3 junk bits 101, then BC×4, then A5 → active rises on the last bit of the 4th BC. Eight edges later: data_out=A5, valid_out=1, one-cycle strobe.
- Broken qualification: BC, BC, BC, 00, then BC×4 → active stays 0 through 00 and rises only after the 4th fresh BC. No strobes before lock.
- Idle in lock: locked; send 3C, BC, 7E → data_out 3C/BC/7E with valid_out 1/0/1 and three strobes, each 8 cycles apart.
- Gap loss: locked; send 16 consecutive 55 words → the 16th word is presented with valid_out=1. On that edge active=0 and lock_lost pulses once. valid_out=0 at the next edge and no further strobes.
- Gap reset: locked; send 15×55, BC, 15×55 → active stays 1 and lock_lost never pulses.
- Async reset mid-lock: assert reset between clock edges while valid_out=1 → all outputs 0 before the next edge. After release, BC×4 is again required for lock.
